// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and a small load FIFO.
// ALU has priority unless it would overtake an older queued load to the same register or the FIFO starves.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  // Shift-register FIFO: entry 0 is the head, entries below count_q are valid.
  logic [ADDR_W-1:0] faddr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] faddr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fdata_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fdata_d [FIFO_DEPTH];
  logic [CntW-1:0]   count_q, count_d;
  logic [StvW-1:0]   starve_q, starve_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic              conflict, force_mem, alu_grant, pop, push;
  logic [CntW-1:0]   wr_idx;

  always_comb begin
    conflict = 1'b0;
    hazard1  = we3_q && (wa3_q == rd_addr1);
    hazard2  = we3_q && (wa3_q == rd_addr2);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CntW'(i) < count_q) begin
        if (faddr_q[i] == alu_addr) conflict = 1'b1;
        if (faddr_q[i] == rd_addr1) hazard1 = 1'b1;
        if (faddr_q[i] == rd_addr2) hazard2 = 1'b1;
      end
    end
  end

  assign force_mem = starve_q >= StvW'(STARVE_LIMIT);
  assign alu_ready = !conflict && !force_mem;
  assign mem_ready = count_q < CntW'(FIFO_DEPTH);
  assign alu_grant = alu_valid && alu_ready;
  assign pop       = !alu_grant && (count_q != '0);
  assign push      = mem_valid && mem_ready;
  assign wr_idx    = pop ? count_q - 1'b1 : count_q;

  always_comb begin
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        faddr_d[i] = faddr_q[i+1];
        fdata_d[i] = fdata_q[i+1];
      end
    end
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (push && (CntW'(i) == wr_idx)) begin
        faddr_d[i] = mem_addr;
        fdata_d[i] = mem_data;
      end
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (alu_grant && (starve_q < StvW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    we3_d = alu_grant || pop;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (alu_grant) begin
      wa3_d = alu_addr;
      wd3_d = alu_data;
    end else if (pop) begin
      wa3_d = faddr_q[0];
      wd3_d = fdata_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faddr_q  <= '{default: '0};
      fdata_q  <= '{default: '0};
      count_q  <= '0;
      starve_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a write-port scoreboard that tracks
// accepted ALU results and queued loads and checks every cycle's write against them.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        hazard1, hazard2;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .ADDR_W      (4),
    .DATA_W      (32),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .hazard1  (hazard1),
    .hazard2  (hazard2),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register-file sink written from the DUT write port.
  logic [31:0] rf [16];
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  // Scoreboard: ALU results must appear the cycle after acceptance; loads in push order.
  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         mem_q [$];
  wr_t         head;
  logic        alu_acc_prev = 1'b0;
  logic        pop_prev     = 1'b0;
  logic [3:0]  alu_a_prev;
  logic [31:0] alu_d_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
      alu_acc_prev = 1'b0;
      pop_prev     = 1'b0;
    end else begin
      check_eq("sb_we3", 32'(we3), 32'(alu_acc_prev || pop_prev));
      if (we3 && alu_acc_prev) begin
        check_eq("sb_alu_wa3", 32'(wa3), 32'(alu_a_prev));
        check_eq("sb_alu_wd3", wd3, alu_d_prev);
      end else if (we3 && pop_prev) begin
        head = mem_q.pop_front();
        check_eq("sb_ld_wa3", 32'(wa3), 32'(head.a));
        check_eq("sb_ld_wd3", wd3, head.d);
      end
      alu_acc_prev = alu_valid && alu_ready;
      alu_a_prev   = alu_addr;
      alu_d_prev   = alu_data;
      pop_prev     = !alu_acc_prev && (mem_q.size() > 0);
      if (mem_valid && mem_ready) mem_q.push_back('{a: mem_addr, d: mem_data});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  bit exp_alu_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  bit exp_mem_rdy [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we3", 32'(we3), 0);
    check_eq("rst_wa3", 32'(wa3), 0);
    check_eq("rst_wd3", wd3, 0);
    check_eq("rst_mem_rdy", 32'(mem_ready), 1);
    check_eq("rst_alu_rdy", 32'(alu_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // ALU only
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'd128;
    @(negedge clk) check_eq("alu_rdy", 32'(alu_ready), 1);
    next_cycle();
    check_eq("alu1_we3", 32'(we3), 1);
    check_eq("alu1_wa3", 32'(wa3), 1);
    check_eq("alu1_wd3", wd3, 128);
    alu_addr = 4'd2; alu_data = 32'd64;
    next_cycle();
    check_eq("alu2_wa3", 32'(wa3), 2);
    check_eq("alu2_wd3", wd3, 64);
    idle(1);
    check_eq("rf_r1", rf[1], 128);
    check_eq("rf_r2", rf[2], 64);
    check_eq("idle_we3", 32'(we3), 0);

    // Load backpressure and starvation guard
    alu_valid = 1'b1; alu_addr = 4'd6;
    for (int c = 0; c < 7; c++) begin
      alu_data = 32'(1000 + c);
      if (c < 3) begin
        mem_valid = 1'b1; mem_addr = 4'(3 + c); mem_data = 32'(300 + c);
      end else begin
        mem_valid = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("bp_alu_rdy_c%0d", c), 32'(alu_ready), 32'(exp_alu_rdy[c]));
      if (c < 3) check_eq($sformatf("bp_mem_rdy_c%0d", c), 32'(mem_ready), 32'(exp_mem_rdy[c]));
      next_cycle();
      if (c == 5) begin
        check_eq("bp_forced_wa3", 32'(wa3), 3);
        check_eq("bp_forced_wd3", wd3, 300);
      end
    end
    idle(3);

    // WAW ordering
    mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'd10;
    next_cycle();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'd20;
    @(negedge clk) check_eq("waw_conflict", 32'(alu_ready), 0);
    next_cycle();
    check_eq("waw_first_wa3", 32'(wa3), 7);
    check_eq("waw_first_wd3", wd3, 10);
    @(negedge clk) check_eq("waw_rdy", 32'(alu_ready), 1);
    next_cycle();
    check_eq("waw_second_wd3", wd3, 20);
    idle(1);
    check_eq("waw_rf_r7", rf[7], 20);
    idle(1);

    // Read hazards
    rd_addr1 = 4'd9; rd_addr2 = 4'd8;
    mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'd99;
    @(negedge clk);
    check_eq("hz1_c0", 32'(hazard1), 0);
    check_eq("hz2_c0", 32'(hazard2), 0);
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    check_eq("hz1_queued", 32'(hazard1), 1);
    check_eq("hz2_queued", 32'(hazard2), 0);
    next_cycle();
    check_eq("hz_we3", 32'(we3), 1);
    check_eq("hz_wa3", 32'(wa3), 9);
    @(negedge clk);
    check_eq("hz1_inflight", 32'(hazard1), 1);
    check_eq("hz2_inflight", 32'(hazard2), 0);
    next_cycle();
    check_eq("hold_we3", 32'(we3), 0);
    check_eq("hold_wa3", 32'(wa3), 9);
    check_eq("hold_wd3", wd3, 99);
    @(negedge clk);
    check_eq("hz1_clear", 32'(hazard1), 0);
    check_eq("hz2_clear", 32'(hazard2), 0);

    // Simultaneous push and pop
    mem_valid = 1'b1; mem_addr = 4'd10; mem_data = 32'hA0;
    next_cycle();
    mem_addr = 4'd11; mem_data = 32'hB0;
    @(negedge clk) check_eq("pp_mem_rdy", 32'(mem_ready), 1);
    next_cycle();
    check_eq("pp_pop_wa3", 32'(wa3), 10);
    mem_valid = 1'b0;
    @(negedge clk) check_eq("pp_mem_rdy_after", 32'(mem_ready), 1);
    next_cycle();
    check_eq("pp_next_we3", 32'(we3), 1);
    check_eq("pp_next_wa3", 32'(wa3), 11);
    check_eq("pp_next_wd3", wd3, 32'hB0);
    next_cycle();
    check_eq("pp_drained_we3", 32'(we3), 0);
    check_eq("sb_drained", 32'(mem_q.size()), 0);

    // Asynchronous reset with two loads buffered
    rd_addr1 = 4'd13; rd_addr2 = 4'd12;
    alu_valid = 1'b1; alu_addr = 4'd12; alu_data = 32'd1200;
    mem_valid = 1'b1; mem_addr = 4'd13; mem_data = 32'd1300;
    next_cycle();
    mem_addr = 4'd14; mem_data = 32'd1400;
    next_cycle();
    mem_valid = 1'b0;
    #1;
    check_eq("pre_rst_hz1", 32'(hazard1), 1);
    check_eq("pre_rst_hz2", 32'(hazard2), 1);
    check_eq("pre_rst_mem_rdy", 32'(mem_ready), 0);
    rst_n = 1'b0;
    alu_valid = 1'b0;
    #1;
    check_eq("arst_we3", 32'(we3), 0);
    check_eq("arst_wa3", 32'(wa3), 0);
    check_eq("arst_wd3", wd3, 0);
    check_eq("arst_mem_rdy", 32'(mem_ready), 1);
    check_eq("arst_alu_rdy", 32'(alu_ready), 1);
    check_eq("arst_hz1", 32'(hazard1), 0);
    check_eq("arst_hz2", 32'(hazard2), 0);
    next_cycle();
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    check_eq("post_rst_we3", 32'(we3), 0);
    check_eq("post_rst_hz1", 32'(hazard1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
